// File: rtl/tetris_pkg.sv
// Shared board geometry, row type and engine state encoding
// for the board clear engine and its row scanner.
package tetris_pkg;

  localparam int ROWS  = 11;
  localparam int COLS  = 8;
  localparam int CNT_W = 8;

  typedef logic [COLS-1:0] row_t;
  typedef logic [3:0]      idx_t;

  localparam idx_t NO_ROW  = 4'd11;
  localparam idx_t TOP_ROW = idx_t'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    SCAN,
    SHIFT
  } eng_state_t;

endpackage

// File: rtl/board_clear_engine_if.sv
// Handshake/bus bundle between the game FSM (master)
// and the board clear engine (slave).
interface board_clear_engine_if;
  import tetris_pkg::*;

  logic                 start_new;
  logic                 start_land;
  logic                 start_clear;
  logic [4*COLS-1:0]    piece_mask;
  idx_t                 piece_row;
  idx_t                 which_row;
  logic                 land_done;
  logic                 clear_done;
  logic                 busy;
  logic                 game_over;
  logic [CNT_W-1:0]     lines_cleared;
  logic [ROWS*COLS-1:0] board_flat;

  modport master (
    output start_new, start_land, start_clear,
    output piece_mask, piece_row,
    input  which_row, land_done, clear_done,
    input  busy, game_over, lines_cleared, board_flat
  );

  modport slave (
    input  start_new, start_land, start_clear,
    input  piece_mask, piece_row,
    output which_row, land_done, clear_done,
    output busy, game_over, lines_cleared, board_flat
  );

endinterface

// File: rtl/board_row_scanner.sv
// Row pointer shared by the full-row scan and the row shift;
// reports whether the pointed row is full and whether it is the top row.
module board_row_scanner
  import tetris_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  idx_t i_start,
  input  logic i_inc,
  input  row_t i_row,
  output idx_t o_idx,
  output logic o_hit,
  output logic o_end
);

  idx_t r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_start;
    end else if (i_inc && (r_ptr != TOP_ROW)) begin
      r_ptr <= r_ptr + 4'd1;
    end
  end

  assign o_idx = r_ptr;
  assign o_hit = &i_row;
  assign o_end = (r_ptr == TOP_ROW);

endmodule

// File: rtl/board_clear_engine.sv
// Settled-board owner: merges landed pieces, finds full rows, deletes them.
// CLEAR_MULTI_EN: after a delete, rescan and keep deleting until no row is full.
module board_clear_engine
  import tetris_pkg::*;
(
  input  logic                 clka,
  input  logic                 restart_n,
  board_clear_engine_if.slave  bus
);

  localparam logic [4:0] ROWS5 = 5'(ROWS);

  eng_state_t       r_state;
  row_t             r_board [ROWS];
  row_t             w_merged [ROWS];
  logic             r_land_q;
  logic             r_clear_q;
  idx_t             r_which;
  logic             r_land_done;
  logic             r_clear_done;
  logic             r_go;
  logic [CNT_W-1:0] r_lines;

  logic w_land_edge;
  logic w_clear_edge;
  logic w_ovf;
  logic w_load;
  logic w_inc;
  logic w_hit;
  logic w_end;
  logic w_rescan;
  idx_t w_start;
  idx_t w_ptr;
  idx_t w_ptr_nx;
  row_t w_prow;
  logic [4:0] w_pidx;

  assign w_land_edge  = bus.start_land & ~r_land_q;
  assign w_clear_edge = bus.start_clear & ~r_clear_q;
  assign w_ptr_nx     = w_ptr + 4'd1;

  board_row_scanner u_scan (
    .clk     (clka),
    .rst_n   (restart_n),
    .i_load  (w_load),
    .i_start (w_start),
    .i_inc   (w_inc),
    .i_row   (r_board[w_ptr]),
    .o_idx   (w_ptr),
    .o_hit   (w_hit),
    .o_end   (w_end)
  );

`ifdef CLEAR_MULTI_EN
  logic r_rescan;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_rescan <= 1'b0;
    end else if (bus.start_new || (r_state == IDLE)) begin
      r_rescan <= 1'b0;
    end else if ((r_state == SHIFT) && w_end) begin
      r_rescan <= 1'b1;
    end
  end

  assign w_rescan = r_rescan;
`else
  assign w_rescan = 1'b0;
`endif

  always_comb begin
    w_load  = 1'b0;
    w_start = r_which;
    w_inc   = 1'b0;
    unique case (r_state)
      IDLE:  w_load = w_clear_edge && (r_which != NO_ROW);
      MERGE: begin
        w_load  = 1'b1;
        w_start = '0;
      end
      SCAN:  w_inc = ~w_hit;
      SHIFT: begin
        w_inc = ~w_end;
`ifdef CLEAR_MULTI_EN
        w_load = w_end;
`endif
      end
      default: ;
    endcase
  end

  // Rows that fall above the board are dropped but still flag game over.
  always_comb begin
    w_merged = r_board;
    w_ovf    = 1'b0;
    w_prow   = '0;
    w_pidx   = '0;
    for (int i = 0; i < 4; i++) begin
      w_prow = bus.piece_mask[i*COLS +: COLS];
      w_pidx = {1'b0, bus.piece_row} + 5'(i);
      if (w_pidx >= ROWS5) begin
        if (|w_prow) w_ovf = 1'b1;
      end else begin
        if (|(w_merged[w_pidx[3:0]] & w_prow)) w_ovf = 1'b1;
        w_merged[w_pidx[3:0]] = w_merged[w_pidx[3:0]] | w_prow;
      end
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_state      <= IDLE;
      for (int r = 0; r < ROWS; r++) r_board[r] <= '0;
      r_which      <= NO_ROW;
      r_land_done  <= 1'b0;
      r_clear_done <= 1'b0;
      r_go         <= 1'b0;
      r_lines      <= '0;
      r_land_q     <= 1'b0;
      r_clear_q    <= 1'b0;
    end else begin
      r_land_q     <= bus.start_land;
      r_clear_q    <= bus.start_clear;
      r_land_done  <= 1'b0;
      r_clear_done <= 1'b0;
      if (bus.start_new) begin
        r_state <= IDLE;
        for (int r = 0; r < ROWS; r++) r_board[r] <= '0;
        r_which <= NO_ROW;
        r_go    <= 1'b0;
        r_lines <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_land_edge) begin
              r_state <= MERGE;
            end else if (w_clear_edge) begin
              if (r_which == NO_ROW) r_clear_done <= 1'b1;
              else                   r_state      <= SHIFT;
            end
          end
          MERGE: begin
            r_board <= w_merged;
            if (w_ovf) r_go <= 1'b1;
            r_state <= SCAN;
          end
          SCAN: begin
            if (w_hit && w_rescan) begin
              r_state <= SHIFT;
            end else if (w_hit || w_end) begin
              r_which      <= w_hit ? w_ptr : NO_ROW;
              r_land_done  <= ~w_rescan;
              r_clear_done <= w_rescan;
              r_state      <= IDLE;
            end
          end
          SHIFT: begin
            if (!w_end) begin
              r_board[w_ptr] <= r_board[w_ptr_nx];
            end else begin
              r_board[TOP_ROW] <= '0;
              if (r_lines != '1) r_lines <= r_lines + 1'b1;
`ifdef CLEAR_MULTI_EN
              r_state <= SCAN;
`else
              r_which      <= NO_ROW;
              r_clear_done <= 1'b1;
              r_state      <= IDLE;
`endif
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.which_row     = r_which;
  assign bus.land_done     = r_land_done;
  assign bus.clear_done    = r_clear_done;
  assign bus.busy          = (r_state != IDLE);
  assign bus.game_over     = r_go;
  assign bus.lines_cleared = r_lines;

  for (genvar g = 0; g < ROWS; g++) begin : g_flat
    assign bus.board_flat[g*COLS +: COLS] = r_board[g];
  end

endmodule
